// File: rtl/exp5_mostra_sequencia_pkg.sv
// Shared codes and defaults for the playback unit.
// State codes double as the hexa7seg display value.
package exp5_mostra_sequencia_pkg;

  typedef enum logic [3:0] {
    OCIOSO = 4'h0,
    BUSCA  = 4'h1,
    ACENDE = 4'h2,
    APAGA  = 4'h3,
    FIM    = 4'hF
  } estado_t;

  localparam int ON_PADRAO  = 1000;
  localparam int OFF_PADRAO = 500;

  // Timer width able to hold max(on, off)-1, never narrower than 1 bit.
  function automatic int largura_timer(int on_c, int off_c);
    int m;
    m = (on_c > off_c) ? on_c : off_c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/exp5_temporizador.sv
// Modulo-M up counter: wraps to 0 on the cycle fim is high.
// M is given as the compare value m_fim = M-1.
module exp5_temporizador #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  input  logic [W-1:0] m_fim,
  output logic         fim
);

  logic [W-1:0] valor;

  assign fim = (valor == m_fim);

  // Count while enabled; the wrap re-zeroes for the next phase.
  always_ff @(posedge clock) begin
    if (reset || zera) begin
      valor <= '0;
    end else if (conta) begin
      valor <= fim ? '0 : valor + W'(1);
    end
  end

endmodule

// File: rtl/exp5_mostra_sequencia.sv
// Playback of the stored jogada sequence on the LEDs.
// Reads addresses 0..limite, lights each, then pulses pronto.
module exp5_mostra_sequencia
  import exp5_mostra_sequencia_pkg::*;
#(
  parameter int ON_CYCLES  = ON_PADRAO,
  parameter int OFF_CYCLES = OFF_PADRAO,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              abortar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [DATA_W-1:0] mem_dado,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic [DATA_W-1:0] leds,
  output logic              ocupado,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam int TW = largura_timer(ON_CYCLES, OFF_CYCLES);

  estado_t           estado;
  logic [ADDR_W-1:0] lim_reg;
  logic [DATA_W-1:0] led_reg;
  logic              t_zera;
  logic              t_conta;
  logic [TW-1:0]     t_m;
  logic              t_fim;

  // Timer runs only while lit or dark; M follows the phase.
  always_comb begin
    t_zera  = 1'b0;
    t_conta = 1'b0;
    t_m     = TW'(OFF_CYCLES - 1);
    unique case (1'b1)
      (estado == ACENDE): begin
        t_conta = 1'b1;
        t_m     = TW'(ON_CYCLES - 1);
      end
      (estado == APAGA): t_conta = 1'b1;
      default:           t_zera  = 1'b1;
    endcase
  end

  exp5_temporizador #(
    .W(TW)
  ) u_tmr (
    .clock (clock),
    .reset (reset),
    .zera  (t_zera),
    .conta (t_conta),
    .m_fim (t_m),
    .fim   (t_fim)
  );

  // Control FSM with inline address counter.
  // Compare precedes increment, so the address never wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= OCIOSO;
      mem_endereco <= '0;
      lim_reg      <= '0;
      led_reg      <= '0;
    end else if (abortar && estado != OCIOSO) begin
      estado <= OCIOSO;
    end else begin
      unique case (estado)
        OCIOSO: begin
          if (iniciar && !abortar) begin
            lim_reg      <= limite;
            mem_endereco <= '0;
            estado       <= BUSCA;
          end
        end
        BUSCA: begin
          led_reg <= mem_dado;
          estado  <= ACENDE;
        end
        ACENDE: begin
          if (t_fim) estado <= APAGA;
        end
        APAGA: begin
          if (t_fim) begin
            if (mem_endereco == lim_reg) begin
              estado <= FIM;
            end else begin
              mem_endereco <= mem_endereco + ADDR_W'(1);
              estado       <= BUSCA;
            end
          end
        end
        FIM:     estado <= OCIOSO;
        default: estado <= OCIOSO;
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    leds      = (estado == ACENDE) ? led_reg : '0;
    ocupado   = (estado != OCIOSO);
    pronto    = (estado == FIM);
    db_estado = estado;
  end

endmodule
